// File: rtl/fg_config_ctrl.sv
// Byte-wide configuration front end: host bytes land in a shadow copy and are
// made live atomically on commit, deferred to a sample boundary while running.
module fg_config_ctrl #(
    parameter int                             CONFIG_REG_BITWIDTH = 64,
    parameter int                             ADDR_BITWIDTH       = 3,
    parameter logic [CONFIG_REG_BITWIDTH-1:0] RESET_CONFIG        = '0,
    parameter int                             TIMEOUT_BITWIDTH    = 16,
    parameter int                             PENDING_TIMEOUT     = 0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           wrEn_i,
    input  logic [ADDR_BITWIDTH-1:0]       addr_i,
    input  logic [7:0]                     data_i,
    input  logic                           commit_i,
    input  logic                           enable_i,
    input  logic                           strobe_i,
    input  logic                           rdSel_i,
    input  logic [ADDR_BITWIDTH-1:0]       rdAddr_i,
    output logic                           ready_o,
    output logic [CONFIG_REG_BITWIDTH-1:0] CR_bus_o,
    output logic                           outputEnable_o,
    output logic                           commitDone_o,
    output logic                           timeout_o,
    output logic [7:0]                     rdData_o
);

    localparam int NUM_BYTES = CONFIG_REG_BITWIDTH / 8;
    localparam logic [TIMEOUT_BITWIDTH-1:0] WD_LAST = TIMEOUT_BITWIDTH'(PENDING_TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } state_t;

    state_t                         state_q, state_d;
    logic [CONFIG_REG_BITWIDTH-1:0] shadow_q, shadow_d;
    logic [CONFIG_REG_BITWIDTH-1:0] active_q, active_d;
    logic [TIMEOUT_BITWIDTH-1:0]    wd_q, wd_d;
    logic                           timeout_q, timeout_d;
    logic                           apply_q, apply_d;
    logic                           commit_done_q;
    logic                           out_en_q;
    logic [7:0]                     rd_data_q, rd_data_d;

    logic                           wr_ok;
    logic [CONFIG_REG_BITWIDTH-1:0] shadow_wr;
    logic [CONFIG_REG_BITWIDTH-1:0] rd_src;
    logic [7:0]                     rd_bytes [NUM_BYTES];

    assign wr_ok  = wrEn_i && (state_q == ST_IDLE);
    assign rd_src = rdSel_i ? active_q : shadow_q;

    // Same-cycle write is merged here so a commit copies the updated byte.
    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_bytes
            assign shadow_wr[gi*8 +: 8] = (wr_ok && (addr_i == ADDR_BITWIDTH'(gi)))
                                          ? data_i : shadow_q[gi*8 +: 8];
            assign rd_bytes[gi] = rd_src[gi*8 +: 8];
        end
    endgenerate

    assign rd_data_d = rd_bytes[rdAddr_i];

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_wr;
        active_d  = active_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;
        apply_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (commit_i) begin
                    if (!out_en_q) begin
                        active_d = shadow_wr;
                        apply_d  = 1'b1;
                    end else begin
                        state_d = ST_PENDING;
                        wd_d    = '0;
                    end
                end
            end
            ST_PENDING: begin
                shadow_d = shadow_q;
                if (!out_en_q || strobe_i) begin
                    active_d = shadow_q;
                    apply_d  = 1'b1;
                    state_d  = ST_IDLE;
                end else if ((PENDING_TIMEOUT != 0) && (wd_q == WD_LAST)) begin
                    active_d  = shadow_q;
                    apply_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (wd_q != '1) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            shadow_q      <= RESET_CONFIG;
            active_q      <= RESET_CONFIG;
            wd_q          <= '0;
            timeout_q     <= 1'b0;
            apply_q       <= 1'b0;
            commit_done_q <= 1'b0;
            out_en_q      <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            wd_q          <= wd_d;
            timeout_q     <= timeout_d;
            apply_q       <= apply_d;
            commit_done_q <= apply_q;
            out_en_q      <= enable_i;
            rd_data_q     <= rd_data_d;
        end
    end

    assign ready_o        = (state_q == ST_IDLE);
    assign CR_bus_o       = active_q;
    assign outputEnable_o = out_en_q;
    assign commitDone_o   = commit_done_q;
    assign timeout_o      = timeout_q;
    assign rdData_o       = rd_data_q;

endmodule

// File: tb/tb_fg_config_ctrl.sv
// Directed bench for fg_config_ctrl: one instance with the watchdog disabled,
// one with a 4-cycle watchdog, sharing the same stimulus.
module tb_fg_config_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [2:0] addr;
    logic [7:0] data;
    logic       commit;
    logic       enable;
    logic       strobe;
    logic       rd_sel;
    logic [2:0] rd_addr;

    logic        ready_a, oe_a, done_a, tmo_a;
    logic [63:0] cr_a;
    logic [7:0]  rd_a;
    logic        ready_b, oe_b, done_b, tmo_b;
    logic [63:0] cr_b;
    logic [7:0]  rd_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fg_config_ctrl dut (
        .clk_i(clk), .rst_i(rst), .wrEn_i(wr_en), .addr_i(addr), .data_i(data),
        .commit_i(commit), .enable_i(enable), .strobe_i(strobe),
        .rdSel_i(rd_sel), .rdAddr_i(rd_addr),
        .ready_o(ready_a), .CR_bus_o(cr_a), .outputEnable_o(oe_a),
        .commitDone_o(done_a), .timeout_o(tmo_a), .rdData_o(rd_a)
    );

    fg_config_ctrl #(.PENDING_TIMEOUT(4)) dut_wd (
        .clk_i(clk), .rst_i(rst), .wrEn_i(wr_en), .addr_i(addr), .data_i(data),
        .commit_i(commit), .enable_i(enable), .strobe_i(strobe),
        .rdSel_i(rd_sel), .rdAddr_i(rd_addr),
        .ready_o(ready_b), .CR_bus_o(cr_b), .outputEnable_o(oe_b),
        .commitDone_o(done_b), .timeout_o(tmo_b), .rdData_o(rd_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; addr = '0; data = '0; commit = 1'b0;
        enable = 1'b0; strobe = 1'b0; rd_sel = 1'b0; rd_addr = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_ready", ready_a, 1);
        chk("rst_cr", cr_a, 64'h0);
        chk("rst_oe", oe_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_tmo", tmo_a, 0);
        chk("rst_rd", rd_a, 8'h00);
        rd_sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            tick();
            chk("rst_rd_act", rd_a, 8'h00);
        end

        // Stopped generator: write all bytes, commit applies immediately
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; addr = 3'(i); data = 8'h10 + 8'(i);
            tick();
            chk("wr_cr_hold", cr_a, 64'h0);
        end
        wr_en = 1'b0;
        rd_sel = 1'b0; rd_addr = 3'd3;
        tick();
        chk("rd_shadow3", rd_a, 8'h13);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("commit_cr", cr_a, 64'h1716151413121110);
        chk("commit_done0", done_a, 0);
        tick();
        chk("commit_done1", done_a, 1);
        tick();
        chk("commit_done2", done_a, 0);

        // Running: commit deferred to strobe; same-cycle strobe ignored
        enable = 1'b1;
        tick();
        chk("oe_on", oe_a, 1);
        wr_en = 1'b1; addr = 3'd1; data = 8'hAA; commit = 1'b1; strobe = 1'b1;
        tick();
        wr_en = 1'b0; commit = 1'b0; strobe = 1'b0;
        chk("pend_ready", ready_a, 0);
        chk("pend_cr", cr_a, 64'h1716151413121110);
        wr_en = 1'b1; addr = 3'd2; data = 8'h55;
        tick();
        wr_en = 1'b0;
        rd_sel = 1'b0; rd_addr = 3'd1;
        tick();
        chk("pend_rd1", rd_a, 8'hAA);
        rd_addr = 3'd2;
        tick();
        chk("pend_rd2", rd_a, 8'h12);
        tick();
        chk("pend_ready2", ready_a, 0);
        chk("pend_cr2", cr_a, 64'h1716151413121110);
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        chk("strobe_cr", cr_a, 64'h171615141312AA10);
        chk("strobe_ready", ready_a, 1);
        tick();
        chk("strobe_done", done_a, 1);

        // Running, pending, then generator stopped
        wr_en = 1'b1; addr = 3'd7; data = 8'hC3; commit = 1'b1;
        tick();
        wr_en = 1'b0; commit = 1'b0;
        chk("stop_ready", ready_a, 0);
        enable = 1'b0;
        tick();
        chk("stop_oe", oe_a, 0);
        chk("stop_cr_hold", cr_a, 64'h171615141312AA10);
        chk("stop_ready2", ready_a, 0);
        tick();
        chk("stop_cr", cr_a, 64'hC31615141312AA10);
        chk("stop_ready3", ready_a, 1);
        chk("stop_tmo", tmo_a, 0);
        tick();
        chk("stop_done", done_a, 1);

        // Reset while pending drops the commit
        enable = 1'b1;
        tick();
        wr_en = 1'b1; addr = 3'd0; data = 8'h77; commit = 1'b1;
        tick();
        wr_en = 1'b0; commit = 1'b0;
        chk("rp_ready", ready_a, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rp_cr", cr_a, 64'h0);
        chk("rp_ready2", ready_a, 1);
        chk("rp_done", done_a, 0);
        rd_sel = 1'b0; rd_addr = 3'd0;
        tick();
        chk("rp_done2", done_a, 0);
        chk("rp_rd_shadow", rd_a, 8'h00);

        // Watchdog instance: forced commit on 4th cycle in PENDING
        chk("wd_tmo0", tmo_b, 0);
        chk("wd_oe", oe_b, 1);
        wr_en = 1'b1; addr = 3'd0; data = 8'h5A; commit = 1'b1;
        tick();
        wr_en = 1'b0; commit = 1'b0;
        chk("wd_ready_p0", ready_b, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("wd_ready_p", ready_b, 0);
            chk("wd_cr_hold", cr_b, 64'h0);
        end
        tick();
        chk("wd_cr", cr_b, 64'h5A);
        chk("wd_tmo1", tmo_b, 1);
        chk("wd_ready", ready_b, 1);
        chk("nowd_ready", ready_a, 0);
        tick();
        chk("wd_done", done_b, 1);
        enable = 1'b0;
        tick();
        wr_en = 1'b1; addr = 3'd1; data = 8'h66; commit = 1'b1;
        tick();
        wr_en = 1'b0; commit = 1'b0;
        chk("wd_cr2", cr_b, 64'h665A);
        chk("wd_tmo_stick", tmo_b, 1);
        chk("nowd_cr", cr_a, 64'h5A);
        chk("nowd_tmo", tmo_a, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wd_tmo_rst", tmo_b, 0);
        chk("wd_cr_rst", cr_b, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fg_config_ctrl.md
Name: fg_config_ctrl

Overview:
- Byte-wide configuration front end for the function generator.
- Host bytes are written into a shadow copy of the 64-bit configuration bus and made live atomically on a commit.
- While the generator is running, a commit is held until the generator's output-valid strobe, so every parameter changes on a sample boundary and the output never shows a half-written configuration.
- Also registers the output-enable request and offers registered readback of the shadow or active copy.

Parameters:
- CONFIG_REG_BITWIDTH, 64, width of shadow/active configuration; must be a multiple of 8.
- ADDR_BITWIDTH, 3, byte address width; 2**ADDR_BITWIDTH == CONFIG_REG_BITWIDTH/8.
- RESET_CONFIG, 64'h0, value loaded into shadow and active on reset.
- TIMEOUT_BITWIDTH, 16, width of the pending-commit watchdog counter.
- PENDING_TIMEOUT, 0, cycles to wait for a strobe before forcing the commit; 0 disables the watchdog.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- wrEn_i  in  1  byte write request, qualified by ready_o.
- addr_i  in  ADDR_BITWIDTH  byte index; 0 = bits 7:0, 7 = bits 63:56.
- data_i  in  8  write data.
- commit_i  in  1  request to copy shadow to active, qualified by ready_o.
- enable_i  in  1  requested generator output enable.
- strobe_i  in  1  generator output-valid strobe (sample boundary).
- rdSel_i  in  1  readback source: 0 = shadow, 1 = active.
- rdAddr_i  in  ADDR_BITWIDTH  readback byte index.
- ready_o  out  1  high when writes and commits are accepted.
- CR_bus_o  out  CONFIG_REG_BITWIDTH  active configuration, drives the generator.
- outputEnable_o  out  1  registered copy of enable_i.
- commitDone_o  out  1  one-cycle pulse, asserted the cycle after the active copy is updated.
- timeout_o  out  1  sticky flag: a commit was forced by the watchdog.
- rdData_o  out  8  registered readback byte.

Behaviour:
- Reset (rst_i high at a clock edge):
  - shadow = active = RESET_CONFIG; FSM = IDLE.
  - ready_o = 1; outputEnable_o = 0; commitDone_o = 0; timeout_o = 0; rdData_o = 0; watchdog = 0.
  - Reset mid-PENDING drops the pending commit without applying it.
- outputEnable_o <= enable_i every cycle (1-cycle latency). "Running" means outputEnable_o == 1.
- Writes: on wrEn_i && ready_o, shadow[8*addr_i +: 8] <= data_i. While ready_o is low, writes are silently ignored.
- Readback: rdData_o <= selected copy[8*rdAddr_i +: 8]; 1-cycle latency; always available, including during PENDING.
- FSM IDLE, ready_o = 1. On commit_i:
  - Next shadow includes any same-cycle write (write merged before copy).
  - If not running: active <= next shadow at this edge; stay IDLE; commitDone_o pulses next cycle.
  - If running: latch next shadow into shadow; go PENDING; clear watchdog. A strobe_i high in the commit cycle is NOT used.
- FSM PENDING, ready_o = 0; shadow frozen. Leave to IDLE and set active <= shadow (commitDone_o pulses next cycle) on the first of, in priority order:
  - outputEnable_o == 0: generator stopped, apply at once.
  - strobe_i == 1.
  - PENDING_TIMEOUT != 0 and watchdog == PENDING_TIMEOUT-1: also set timeout_o.
  - Otherwise the watchdog increments, saturating at its maximum.
- timeout_o clears only on reset.
- commit_i in PENDING is ignored; it does not queue.
- CR_bus_o changes only at the edge that applies a commit, or at reset; never byte by byte.
- Address decode is exhaustive; no out-of-range addresses are possible.

Test Plan:
- Reset, then read all active bytes (rdSel_i=1) -> each rdData_o = 0; ready_o = 1; CR_bus_o = 0; outputEnable_o = 0.
- enable_i = 0; write bytes 0..7 = 8'h10..8'h17; CR_bus_o stays 0; commit -> next edge CR_bus_o = 64'h1716151413121110; commitDone_o pulses exactly 1 cycle later.
- enable_i = 1 (running); write byte 1 = 8'hAA with commit_i the same cycle, strobe_i also high that cycle -> PENDING, ready_o = 0, CR_bus_o unchanged; a write to byte 2 during PENDING is ignored; strobe_i high 5 cycles later -> bits 15:8 = 8'hAA, byte 2 unchanged, ready_o back to 1.
- Running, commit pending, enable_i dropped -> outputEnable_o falls next edge; commit applies the edge after that; timeout_o stays 0.
- PENDING_TIMEOUT = 4, running, no strobe -> commit applied on the 4th cycle in PENDING; timeout_o = 1 and stays 1 through later commits until rst_i.
- rst_i asserted while PENDING -> CR_bus_o = RESET_CONFIG, no commitDone_o pulse, FSM IDLE, ready_o = 1.
